// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared state type and default widths for the FSMC register bank
package fsmc_pkg;

  localparam int FSMC_DATA_W = 16;
  localparam int FSMC_AD_W   = 18;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DECODE,
    WRITE,
    READ,
    DRAIN
  } fsmc_state_e;

endpackage

// File: rtl/fsmc_sync.sv
// rtl/fsmc_sync.sv - STAGES-deep multi-bit synchroniser; all bits share one delay
module fsmc_sync #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) begin
        stage_q[i] <= RST_VAL;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/fsmc_reg_bank.sv
// rtl/fsmc_reg_bank.sv - FSMC multiplexed-bus slave decoding into NUM_REGS registers
// Optional stuck-strobe timeout: FSMC_REG_TIMEOUT_EN.
module fsmc_reg_bank
  import fsmc_pkg::*;
#(
  parameter int                  DATA_W      = FSMC_DATA_W,
  parameter int                  AD_W        = FSMC_AD_W,
  parameter int                  NUM_REGS    = 8,
  parameter logic [AD_W-1:0]     BASE        = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  inout  wire  [AD_W-1:0]              AD,
  input  logic                         NADV,
  input  logic                         NWE,
  input  logic                         NOE,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic [NUM_REGS-1:0]          rd_pulse
`ifdef FSMC_REG_TIMEOUT_EN
  ,
  output logic                         timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SW    = AD_W + 3;

  logic [SW-1:0]   sync_out;
  logic            nadv_s, nwe_s, noe_s;
  logic [AD_W-1:0] ad_s;

  // Strobes reset to their inactive (high) level so the FSM stays idle while the chain refills.
  fsmc_sync #(
    .WIDTH   (SW),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({3'b111, {AD_W{1'b0}}})
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({NADV, NWE, NOE, AD}),
    .dout  (sync_out)
  );

  assign {nadv_s, nwe_s, noe_s, ad_s} = sync_out;

  fsmc_state_e         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                oe_q, oe_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;
  logic [DATA_W-1:0]   bank_q [NUM_REGS];
  logic [DATA_W-1:0]   bank_d [NUM_REGS];
  logic                tmo;
  logic                commit;
  logic [DATA_W-1:0]   rd_sel;

`ifdef FSMC_REG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // Counts cycles spent in the current non-idle state; a stuck strobe never changes state.
  assign tmo = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d         = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
    timeout_err_d = timeout_err_q | tmo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!nadv_s) state_d = ADDR;
      ADDR:    if (nadv_s) state_d = DECODE;
      DECODE: begin
        if (!nwe_s && !noe_s)  state_d = DRAIN;
        else if (!nwe_s)       state_d = WRITE;
        else if (!noe_s)       state_d = READ;
        else if (!nadv_s)      state_d = ADDR;
      end
      WRITE:   if (nwe_s) state_d = IDLE;
      READ:    if (noe_s) state_d = IDLE;
      DRAIN:   if (nwe_s && noe_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) state_d = IDLE;
  end

  assign rd_sel = RO_MASK[idx_q] ? hw_status[idx_q*DATA_W +: DATA_W] : bank_q[idx_q];
  assign commit = (state_q == WRITE) && nwe_s && hit_q && !RO_MASK[idx_q] && !tmo;

  always_comb begin
    idx_d      = idx_q;
    hit_d      = hit_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bank_d[i] = bank_q[i];
    end

    if (state_q == ADDR && nadv_s) begin
      idx_d = ad_s[IDX_W-1:0];
      hit_d = (ad_s[AD_W-1:IDX_W] == BASE[AD_W-IDX_W-1:0]);
    end

    if (!nwe_s) wdata_d = ad_s[DATA_W-1:0];

    if (commit) begin
      bank_d[idx_q]     = wdata_q;
      wr_pulse_d[idx_q] = 1'b1;
    end

    if (state_q == DECODE && state_d == READ) begin
      rd_data_d         = rd_sel;
      rd_pulse_d[idx_q] = hit_q;
    end

    // Registered enable so release lags NOE by the same depth as the drive does.
    oe_d = (state_d == READ) && hit_q && !noe_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      hit_q      <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      oe_q       <= 1'b0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      oe_q       <= oe_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= bank_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = bank_q[g];
  end

  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

  assign AD[DATA_W-1:0] = oe_q ? rd_data_q : {DATA_W{1'bz}};
  if (AD_W > DATA_W) begin : g_upper
    assign AD[AD_W-1:DATA_W] = {(AD_W-DATA_W){1'bz}};
  end

endmodule

// File: tb/tb_fsmc_reg_bank.sv
// tb/tb_fsmc_reg_bank.sv - randomized self-checking bench for fsmc_reg_bank
module tb_fsmc_reg_bank;

  localparam int              DW = 16;
  localparam int              AW = 18;
  localparam int              NR = 8;
  localparam int              IW = 3;
  localparam int              SS = 2;
  localparam int              TO = 16;
  localparam logic [AW-1:0]   BASE_V = 18'h00155;
  localparam logic [NR-1:0]   RO_V   = 8'h80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic nadv = 1'b1, nwe = 1'b1, noe = 1'b1;
  logic [AW-1:0] ad_drv = '0;
  logic ad_oe = 1'b0;
  wire  [AW-1:0] ad_bus;
  assign ad_bus = ad_oe ? ad_drv : {AW{1'bz}};

  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] hw_status;
  logic [NR-1:0]    wr_pulse, rd_pulse;
`ifdef FSMC_REG_TIMEOUT_EN
  logic             timeout_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [NR];

  always #5 clk = ~clk;

  fsmc_reg_bank #(
    .DATA_W      (DW),
    .AD_W        (AW),
    .NUM_REGS    (NR),
    .BASE        (BASE_V),
    .RO_MASK     (RO_V),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .AD        (ad_bus),
    .NADV      (nadv),
    .NWE       (nwe),
    .NOE       (noe),
    .reg_q     (reg_q),
    .hw_status (hw_status),
    .wr_pulse  (wr_pulse),
    .rd_pulse  (rd_pulse)
`ifdef FSMC_REG_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  function automatic logic [AW-1:0] addr_of(input int idx, input bit hit);
    logic [AW-IW-1:0] up;
    up = BASE_V[AW-IW-1:0];
    if (!hit) up = up ^ (AW-IW)'($urandom_range(1, (1 << (AW-IW)) - 1));
    return {up, IW'(idx)};
  endfunction

  // Undriven bits read as z (4-state) or 0 (2-state); any 1 means someone drives.
  function automatic bit released(input logic [DW-1:0] v);
    return ((|v) !== 1'b1);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int idx);
    return RO_V[idx] ? hw_status[idx*DW +: DW] : model[idx];
  endfunction

  function automatic logic [NR*DW-1:0] flat_model();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = DW'($urandom);
    if (d == '0) d = 16'h0001;
    return d;
  endfunction

  task automatic addr_phase(input logic [AW-1:0] a);
    ad_oe  = 1'b1;
    ad_drv = a;
    nadv   = 1'b0;
    repeat (SS + 2) @(negedge clk);
    nadv   = 1'b1;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic do_write(input int idx, input bit hit, input logic [DW-1:0] data, input string tag);
    int            pulses;
    int            first_k;
    logic [NR-1:0] seen;
    logic [NR-1:0] exp_vec;
    int            exp_pulses;
    addr_phase(addr_of(idx, hit));
    ad_drv = {{(AW-DW){1'b0}}, data};
    nwe    = 1'b0;
    repeat (SS + 4) @(negedge clk);
    nwe     = 1'b1;
    pulses  = 0;
    first_k = -1;
    seen    = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wr_pulse !== '0) begin
        pulses++;
        seen = seen | wr_pulse;
        if (first_k < 0) first_k = k;
      end
      if (k == 1) ad_oe = 1'b0;
    end
    exp_pulses = (hit && !RO_V[idx]) ? 1 : 0;
    exp_vec    = exp_pulses ? NR'(1 << idx) : '0;
    if (exp_pulses == 1) model[idx] = data;

    checks++;
    if (pulses !== exp_pulses) begin
      errors++;
      $display("FAIL %s wr_pulse cycles: got %0d expected %0d", tag, pulses, exp_pulses);
    end
    checks++;
    if (seen !== exp_vec) begin
      errors++;
      $display("FAIL %s wr_pulse vector: got %b expected %b", tag, seen, exp_vec);
    end
    if (exp_pulses == 1) begin
      checks++;
      if (first_k !== SS + 1) begin
        errors++;
        $display("FAIL %s write latency: got %0d expected %0d", tag, first_k, SS + 1);
      end
    end
    checks++;
    if (reg_q !== flat_model()) begin
      errors++;
      $display("FAIL %s reg_q: got %h expected %h", tag, reg_q, flat_model());
    end
  endtask

  task automatic do_read(input int idx, input bit hit, input string tag);
    logic [DW-1:0] exp;
    logic [DW-1:0] v;
    logic [NR-1:0] exp_rp;
    int            ad_bad, rp_bad, bad_k;
    logic [DW-1:0] bad_v;
    bit            drive_exp;
    exp    = exp_rd(idx);
    ad_bad = 0;
    rp_bad = 0;
    bad_k  = -1;
    bad_v  = '0;
    addr_phase(addr_of(idx, hit));
    ad_oe = 1'b0;
    noe   = 1'b0;
    for (int k = 1; k <= SS + 6; k++) begin
      @(negedge clk);
      v         = ad_bus[DW-1:0];
      drive_exp = hit && (k >= SS + 1);
      if (drive_exp ? (v !== exp) : !released(v)) begin
        ad_bad++;
        if (bad_k < 0) begin bad_k = k; bad_v = v; end
      end
      exp_rp = (hit && k == SS + 1) ? NR'(1 << idx) : '0;
      if (rd_pulse !== exp_rp) rp_bad++;
    end
    noe = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      v         = ad_bus[DW-1:0];
      drive_exp = hit && (k < SS + 1);
      if (drive_exp ? (v !== exp) : !released(v)) begin
        ad_bad++;
        if (bad_k < 0) begin bad_k = 100 + k; bad_v = v; end
      end
      if (rd_pulse !== '0) rp_bad++;
    end
    checks++;
    if (ad_bad != 0) begin
      errors++;
      $display("FAIL %s AD drive: %0d bad cycles, first at step %0d got %h expected %h hit=%0d",
               tag, ad_bad, bad_k, bad_v, exp, hit);
    end
    checks++;
    if (rp_bad != 0) begin
      errors++;
      $display("FAIL %s rd_pulse: got %0d bad cycles expected 0", tag, rp_bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_q !== '0) begin errors++; $display("FAIL reset reg_q: got %h expected 0", reg_q); end
    checks++;
    if (wr_pulse !== '0 || rd_pulse !== '0) begin
      errors++; $display("FAIL reset pulses: got %b/%b expected 0/0", wr_pulse, rd_pulse);
    end
    checks++;
    if (!released(ad_bus[DW-1:0])) begin
      errors++; $display("FAIL reset AD: got %h expected released", ad_bus[DW-1:0]);
    end
`ifdef FSMC_REG_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset timeout_err: got %b expected 0", timeout_err);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read_idx3();
    do_write(3, 1'b1, 16'hA5A5, "write_idx3");
    do_read(3, 1'b1, "read_idx3");
  endtask

  task automatic test_ro();
    do_write(7, 1'b1, 16'hFFFF, "ro_write");
    do_read(7, 1'b1, "ro_read");
  endtask

  task automatic test_miss();
    do_write(3, 1'b0, 16'h5A5A, "miss_write");
    do_read(3, 1'b0, "miss_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NR; i++) begin
      if (!RO_V[i]) do_write(i, 1'b1, rand_data(), "b2b_write");
    end
    for (int i = 0; i < NR; i++) do_read(i, 1'b1, "b2b_read");
  endtask

  task automatic test_random();
    int  idx;
    bit  hit;
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, NR - 1);
      hit = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) do_write(idx, hit, rand_data(), "rand_write");
      else                           do_read(idx, hit, "rand_read");
    end
  endtask

  task automatic test_drain_and_reset();
    int bad;
    bad = 0;
    addr_phase(addr_of(2, 1'b1));
    ad_oe = 1'b0;
    nwe   = 1'b0;
    noe   = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (!released(ad_bus[DW-1:0]) || wr_pulse !== '0 || rd_pulse !== '0) bad++;
    end
    nwe = 1'b1;
    noe = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (wr_pulse !== '0 || rd_pulse !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drain activity: got %0d bad cycles expected 0", bad); end
    checks++;
    if (reg_q !== flat_model()) begin
      errors++; $display("FAIL drain reg_q: got %h expected %h", reg_q, flat_model());
    end

    bad = 0;
    addr_phase(addr_of(2, 1'b1));
    ad_drv = {{(AW-DW){1'b0}}, 16'hBEEF};
    nwe    = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nwe   = 1'b1;
    ad_oe = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wr_pulse !== '0) bad++;
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midwrite reset wr_pulse: got %0d cycles expected 0", bad); end
    checks++;
    if (reg_q !== '0) begin errors++; $display("FAIL midwrite reset reg_q: got %h expected 0", reg_q); end
    checks++;
    if (!released(ad_bus[DW-1:0])) begin
      errors++; $display("FAIL midwrite reset AD: got %h expected released", ad_bus[DW-1:0]);
    end
    do_write(5, 1'b1, 16'h0C3C, "post_reset_write");
    do_read(5, 1'b1, "post_reset_read");
  endtask

`ifdef FSMC_REG_TIMEOUT_EN
  task automatic test_timeout();
    int            drv;
    logic [DW-1:0] exp;
    do_write(3, 1'b1, 16'h3C3C, "tmo_setup");
    exp = exp_rd(3);
    drv = 0;
    addr_phase(addr_of(3, 1'b1));
    ad_oe = 1'b0;
    noe   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ad_bus[DW-1:0] === exp) drv++;
    end
    checks++;
    if (drv != TO) begin errors++; $display("FAIL timeout drive cycles: got %0d expected %0d", drv, TO); end
    checks++;
    if (!released(ad_bus[DW-1:0])) begin
      errors++; $display("FAIL timeout AD: got %h expected released", ad_bus[DW-1:0]);
    end
    noe = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err sticky: got %b expected 1", timeout_err); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = '0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err clear: got %b expected 0", timeout_err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NR; i++) begin
      model[i] = '0;
      hw_status[i*DW +: DW] = rand_data();
    end
    hw_status[7*DW +: DW] = 16'h1234;
    test_reset();
    test_write_read_idx3();
    test_ro();
    test_miss();
    test_back_to_back();
    test_random();
    test_drain_and_reset();
`ifdef FSMC_REG_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
